nv_nvdla_mcif_read_eg_pack_dma4: RTL and testbench
==================================================

Name: nv_nvdla_mcif_read_eg_pack_dma4

Overview:
- Return-data packer for read client 4 (rbk) in the MCIF read egress path.
- Accepts 256-bit read-return beats from the egress demux, pairs them into 512-bit DMA packets with a 2-bit half mask, and drives the 514-bit dma4 interface.
- Sits directly upstream of the dma4 pipe stage: dma4_vld/dma4_rdy/dma4_pd here connect straight to that stage's inputs.
- Holds one half-packet plus one registered output packet.

Parameters:
- DW, 256, width of one read-return beat; output data width is 2*DW
- CNTW, 32, width of the emitted-packet status counter

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- rq_vld  in  1  read-return beat valid
- rq_rdy  out  1  read-return beat ready
- rq_data  in  DW  beat data
- rq_last  in  1  last beat of the request
- dma4_vld  out  1  packet valid to the dma4 pipe stage
- dma4_rdy  in  1  packet ready from the dma4 pipe stage
- dma4_pd  out  2*DW+2  {mask[1:0], data[2*DW-1:0]}; mask[0] = lower half valid, mask[1] = upper half valid
- pkt_cnt  out  CNTW  packets emitted (dma4_vld & dma4_rdy), wraps
- half_cnt  out  CNTW  packets emitted with mask 2'b01, wraps

Behaviour:
- Clock nvdla_core_clk; reset nvdla_core_rstn, asynchronous, active-low.
- Reset values: state=LO_EMPTY, dma4_vld=0, pkt_cnt=0, half_cnt=0. Data registers (held lower half, dma4_pd data field) are not reset. dma4_pd mask resets to 2'b00.
- Definitions:
  - acc = rq_vld & rq_rdy
  - out_free = !dma4_vld | dma4_rdy
  - rq_rdy = out_free in LO_HELD; in LO_EMPTY, rq_rdy = out_free | !rq_last
- rq_rdy depends combinationally on rq_last but never on rq_vld. dma4_rdy reaches rq_rdy combinationally (allowed: the downstream stage registers its ready).
- FSM LO_EMPTY:
  - acc & !rq_last: capture rq_data as lower half; go to LO_HELD. No output write.
  - acc & rq_last: load output with {2'b01, {DW{1'b0}}, rq_data}; dma4_vld=1; stay in LO_EMPTY.
- FSM LO_HELD:
  - acc (rq_last or not): load output with {2'b11, rq_data, held_lo}; dma4_vld=1; go to LO_EMPTY.
  - A last on the upper beat ends the request normally. Odd-length requests end with a 2'b01 packet.
- Output register:
  - dma4_vld clears on dma4_vld & dma4_rdy when no load occurs in the same cycle.
  - Simultaneous drain and load: dma4_vld stays 1 and dma4_pd takes the new packet (no bubble).
  - dma4_pd is stable while dma4_vld & !dma4_rdy.
- Latency: a completing beat is accepted in cycle N and dma4_vld=1 in cycle N+1.
- Throughput: 1 beat/cycle sustained with dma4_rdy=1, i.e. one packet per 2 beats.
- Backpressure: with dma4_vld=1 and dma4_rdy=0:
  - In LO_EMPTY, a non-last beat is still accepted (fills the hold register).
  - Any packet-completing beat stalls.
- Counters: pkt_cnt increments on dma4_vld & dma4_rdy; half_cnt increments on the same handshake when mask==2'b01. Both wrap from all-ones to 0.
- Reset mid-operation (held half or pending output) discards all in-flight data. After reset, the first beat is treated as a lower half.

Decomposition:
- Shared package nv_nvdla_mcif_eg_pkg:
  - half-mask constants MASK_LO=2'b01, MASK_FULL=2'b11
  - FSM state enum {LO_EMPTY, LO_HELD}
  - dma pd field offsets (mask at [2*DW+1:2*DW])
- One sub-module is natural: nv_nvdla_mcif_eg_pd_reg, a generic valid/ready output register with load/drain and no-bubble overlap. It is reusable for the other dma clients' packers.

Test Plan:
- Two beats A=0x11..., B=0x22... with rq_last on B, dma4_rdy=1 -> one packet mask=2'b11, data={B,A}, dma4_vld one cycle after B accepted; pkt_cnt=1.
- Single beat C with rq_last, dma4_rdy=1 -> packet mask=2'b01, data upper=0, lower=C; pkt_cnt=1, half_cnt=1.
- 3-beat request D,E,F(last) -> packets {2'b11,E,D} then {2'b01,0,F}; half_cnt=1.
- dma4_rdy=0 with a packet pending:
  - lower beat G accepted (rq_rdy=1); next beat stalls (rq_rdy=0);
  - raise dma4_rdy -> pending packet drains and the {H,G} packet loads the same cycle with no bubble;
  - dma4_pd is unchanged during the stall.
- Continuous 16-beat stream with dma4_rdy=1 -> 8 packets on consecutive-pair cycles; rq_rdy never drops; pkt_cnt=8.
- Assert nvdla_core_rstn low while in LO_HELD with dma4_vld=1 -> dma4_vld=0 and counters=0 immediately; next beat J(last) produces mask 2'b01 with lower=J.

Source files
------------

// File: rtl/nv_nvdla_mcif_eg_pkg.sv
// Shared definitions for the MCIF read egress packers: half masks,
// packer FSM states and dma pd field placement.
package nv_nvdla_mcif_eg_pkg;

    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_FULL = 2'b11;
    localparam int         MASK_W    = 2;

    typedef enum logic [0:0] {
        LO_EMPTY = 1'b0,
        LO_HELD  = 1'b1
    } pack_state_e;

    // Mask field sits directly above the 2*DW data field.
    function automatic int pd_mask_lsb(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/nv_nvdla_mcif_eg_pd_reg.sv
// Valid/ready output register: a load may overlap a drain without a bubble.
// Only the top RW bits (the header) are reset; the payload is not.
module nv_nvdla_mcif_eg_pd_reg #(
    parameter int PW = 514,
    parameter int RW = 2
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          load,
    input  logic [PW-1:0] load_pd,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [PW-1:0] out_pd,
    output logic          out_free
);

    logic               vld_r;
    logic [RW-1:0]      hdr_r;
    logic [PW-RW-1:0]   data_r;

    // Valid flag: set by load, cleared by a drain with no concurrent load.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_r <= 1'b0;
        end else if (load) begin
            vld_r <= 1'b1;
        end else if (out_rdy) begin
            vld_r <= 1'b0;
        end else begin
            vld_r <= vld_r;
        end
    end

    // Header (mask) field, reset so an idle output shows no valid halves.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hdr_r <= {RW{1'b0}};
        end else if (load) begin
            hdr_r <= load_pd[PW-1:PW-RW];
        end else begin
            hdr_r <= hdr_r;
        end
    end

    // Payload register, deliberately without reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (load) begin
            data_r <= load_pd[PW-RW-1:0];
        end else begin
            data_r <= data_r;
        end
    end

    assign out_vld  = vld_r;
    assign out_pd   = {hdr_r, data_r};
    assign out_free = !vld_r | out_rdy;

endmodule

// File: rtl/nv_nvdla_mcif_read_eg_pack_dma4.sv
// Read client 4 (rbk) return-data packer: pairs 256-bit beats into
// 512-bit dma4 packets with a half mask, plus emitted-packet counters.
module nv_nvdla_mcif_read_eg_pack_dma4
    import nv_nvdla_mcif_eg_pkg::*;
#(
    parameter int DW   = 256,
    parameter int CNTW = 32
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              rq_vld,
    output logic              rq_rdy,
    input  logic [DW-1:0]     rq_data,
    input  logic              rq_last,
    output logic              dma4_vld,
    input  logic              dma4_rdy,
    output logic [2*DW+1:0]   dma4_pd,
    output logic [CNTW-1:0]   pkt_cnt,
    output logic [CNTW-1:0]   half_cnt
);

    localparam int PW       = 2 * DW + MASK_W;
    localparam int MASK_LSB = pd_mask_lsb(DW);

    pack_state_e      state_r;
    pack_state_e      state_nxt_s;
    logic [DW-1:0]    held_lo_r;
    logic             hold_en_s;
    logic             acc_s;
    logic             out_free_s;
    logic             load_s;
    logic [PW-1:0]    load_pd_s;
    logic             drain_s;
    logic [CNTW-1:0]  pkt_cnt_r;
    logic [CNTW-1:0]  half_cnt_r;

    // Ready: a non-last lower beat only needs the hold register, never the output.
    always_comb begin
        rq_rdy = out_free_s;
        case (state_r)
            LO_EMPTY: rq_rdy = out_free_s | !rq_last;
            LO_HELD:  rq_rdy = out_free_s;
            default:  rq_rdy = out_free_s;
        endcase
    end

    assign acc_s = rq_vld & rq_rdy;

    // Next state, hold-register capture and output load.
    always_comb begin
        state_nxt_s = state_r;
        hold_en_s   = 1'b0;
        load_s      = 1'b0;
        load_pd_s   = {PW{1'b0}};
        case (state_r)
            LO_EMPTY: begin
                if (acc_s && rq_last) begin
                    load_s    = 1'b1;
                    load_pd_s = {MASK_LO, {DW{1'b0}}, rq_data};
                end else if (acc_s) begin
                    hold_en_s   = 1'b1;
                    state_nxt_s = LO_HELD;
                end else begin
                    state_nxt_s = LO_EMPTY;
                end
            end
            LO_HELD: begin
                if (acc_s) begin
                    load_s      = 1'b1;
                    load_pd_s   = {MASK_FULL, rq_data, held_lo_r};
                    state_nxt_s = LO_EMPTY;
                end else begin
                    state_nxt_s = LO_HELD;
                end
            end
            default: state_nxt_s = LO_EMPTY;
        endcase
    end

    // Packer state register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r <= LO_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Held lower half; stale contents are harmless since state gates its use.
    always_ff @(posedge nvdla_core_clk) begin
        if (hold_en_s) begin
            held_lo_r <= rq_data;
        end else begin
            held_lo_r <= held_lo_r;
        end
    end

    nv_nvdla_mcif_eg_pd_reg #(
        .PW (PW),
        .RW (MASK_W)
    ) u_pd_reg (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .load            (load_s),
        .load_pd         (load_pd_s),
        .out_vld         (dma4_vld),
        .out_rdy         (dma4_rdy),
        .out_pd          (dma4_pd),
        .out_free        (out_free_s)
    );

    assign drain_s = dma4_vld & dma4_rdy;

    // Emitted-packet counters; both wrap naturally.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pkt_cnt_r  <= {CNTW{1'b0}};
            half_cnt_r <= {CNTW{1'b0}};
        end else if (drain_s) begin
            pkt_cnt_r <= pkt_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            if (dma4_pd[MASK_LSB +: MASK_W] == MASK_LO) begin
                half_cnt_r <= half_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                half_cnt_r <= half_cnt_r;
            end
        end else begin
            pkt_cnt_r  <= pkt_cnt_r;
            half_cnt_r <= half_cnt_r;
        end
    end

    assign pkt_cnt  = pkt_cnt_r;
    assign half_cnt = half_cnt_r;

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_pack_dma4.sv
// Directed self-checking bench for the dma4 return-data packer.
module tb_nv_nvdla_mcif_read_eg_pack_dma4;

    localparam int DW   = 256;
    localparam int CNTW = 32;

    logic              nvdla_core_clk;
    logic              nvdla_core_rstn;
    logic              rq_vld;
    logic              rq_rdy;
    logic [DW-1:0]     rq_data;
    logic              rq_last;
    logic              dma4_vld;
    logic              dma4_rdy;
    logic [2*DW+1:0]   dma4_pd;
    logic [CNTW-1:0]   pkt_cnt;
    logic [CNTW-1:0]   half_cnt;

    int checks;
    int errors;

    nv_nvdla_mcif_read_eg_pack_dma4 #(.DW(DW), .CNTW(CNTW)) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .rq_vld          (rq_vld),
        .rq_rdy          (rq_rdy),
        .rq_data         (rq_data),
        .rq_last         (rq_last),
        .dma4_vld        (dma4_vld),
        .dma4_rdy        (dma4_rdy),
        .dma4_pd         (dma4_pd),
        .pkt_cnt         (pkt_cnt),
        .half_cnt        (half_cnt)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    task automatic chk(input string tag, input logic [2*DW+1:0] obs, input logic [2*DW+1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a beat, wait (bounded) for ready, then let it be accepted.
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        rq_vld  = 1'b1;
        rq_data = d;
        rq_last = last;
        n = 0;
        @(negedge nvdla_core_clk);
        while (!rq_rdy && n < 20) begin
            n++;
            @(negedge nvdla_core_clk);
        end
        if (n >= 20) begin
            chk("send_timeout", 1'b1, 1'b0);
        end
        @(posedge nvdla_core_clk);
        #1;
        rq_vld  = 1'b0;
        rq_last = 1'b0;
    endtask

    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    function automatic logic [DW-1:0] seq(input int i);
        logic [31:0] w;
        w = 32'h0000_0100 + i;
        return {8{w}};
    endfunction

    logic [DW-1:0]   a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s, p_s, j_s, k_s, l_s;
    logic [2*DW+1:0] hold_pd;
    logic [DW-1:0]   zero_s;

    initial begin
        checks  = 0;
        errors  = 0;
        zero_s  = {DW{1'b0}};
        a_s = pat(8'h11); b_s = pat(8'h22); c_s = pat(8'h33);
        d_s = pat(8'h44); e_s = pat(8'h55); f_s = pat(8'h66);
        g_s = pat(8'h77); h_s = pat(8'h88); p_s = pat(8'h99);
        j_s = pat(8'hAA); k_s = pat(8'hBB); l_s = pat(8'hCC);

        nvdla_core_rstn = 1'b0;
        rq_vld   = 1'b0;
        rq_data  = {DW{1'b0}};
        rq_last  = 1'b0;
        dma4_rdy = 1'b1;
        #12;
        chk("rst_vld",  dma4_vld, 1'b0);
        chk("rst_pkt",  pkt_cnt, 32'd0);
        chk("rst_half", half_cnt, 32'd0);
        chk("rst_mask", dma4_pd[2*DW+1:2*DW], 2'b00);
        nvdla_core_rstn = 1'b1;
        step();

        // Two-beat request
        send(a_s, 1'b0);
        chk("t1_no_pkt_after_lo", dma4_vld, 1'b0);
        send(b_s, 1'b1);
        chk("t1_vld", dma4_vld, 1'b1);
        chk("t1_pd", dma4_pd, {2'b11, b_s, a_s});
        step();
        chk("t1_drained", dma4_vld, 1'b0);
        chk("t1_pkt", pkt_cnt, 32'd1);
        chk("t1_half", half_cnt, 32'd0);

        // Single-beat request
        send(c_s, 1'b1);
        chk("t2_vld", dma4_vld, 1'b1);
        chk("t2_pd", dma4_pd, {2'b01, zero_s, c_s});
        step();
        chk("t2_pkt", pkt_cnt, 32'd2);
        chk("t2_half", half_cnt, 32'd1);

        // Three-beat request
        send(d_s, 1'b0);
        send(e_s, 1'b0);
        chk("t3_pd0", dma4_pd, {2'b11, e_s, d_s});
        send(f_s, 1'b1);
        chk("t3_vld1", dma4_vld, 1'b1);
        chk("t3_pd1", dma4_pd, {2'b01, zero_s, f_s});
        chk("t3_pkt_mid", pkt_cnt, 32'd3);
        step();
        chk("t3_pkt", pkt_cnt, 32'd4);
        chk("t3_half", half_cnt, 32'd2);

        // Backpressure with a pending packet
        dma4_rdy = 1'b0;
        send(p_s, 1'b1);
        chk("t4_pend_vld", dma4_vld, 1'b1);
        hold_pd = dma4_pd;
        chk("t4_pend_pd", hold_pd, {2'b01, zero_s, p_s});
        send(g_s, 1'b0);
        chk("t4_pd_stable0", dma4_pd, hold_pd);
        rq_vld  = 1'b1;
        rq_data = h_s;
        rq_last = 1'b0;
        @(negedge nvdla_core_clk);
        chk("t4_stall_rdy", rq_rdy, 1'b0);
        step();
        @(negedge nvdla_core_clk);
        chk("t4_stall_rdy2", rq_rdy, 1'b0);
        chk("t4_pd_stable1", dma4_pd, hold_pd);
        chk("t4_pkt_hold", pkt_cnt, 32'd4);
        @(posedge nvdla_core_clk);
        #1;
        dma4_rdy = 1'b1;
        @(negedge nvdla_core_clk);
        chk("t4_release_rdy", rq_rdy, 1'b1);
        step();
        rq_vld = 1'b0;
        chk("t4_nobubble_vld", dma4_vld, 1'b1);
        chk("t4_nobubble_pd", dma4_pd, {2'b11, h_s, g_s});
        chk("t4_pkt", pkt_cnt, 32'd5);
        chk("t4_half", half_cnt, 32'd3);
        step();
        chk("t4_pkt2", pkt_cnt, 32'd6);

        // Continuous 16-beat stream
        for (int i = 0; i < 16; i++) begin
            rq_vld  = 1'b1;
            rq_data = seq(i);
            rq_last = (i % 2 == 1);
            @(negedge nvdla_core_clk);
            chk($sformatf("t5_rdy_%0d", i), rq_rdy, 1'b1);
            step();
            if (i % 2 == 1) begin
                chk($sformatf("t5_vld_%0d", i), dma4_vld, 1'b1);
                chk($sformatf("t5_pd_%0d", i), dma4_pd, {2'b11, seq(i), seq(i - 1)});
            end else begin
                chk($sformatf("t5_idle_%0d", i), dma4_vld, 1'b0);
            end
        end
        rq_vld  = 1'b0;
        rq_last = 1'b0;
        step();
        chk("t5_pkt", pkt_cnt, 32'd14);
        chk("t5_half", half_cnt, 32'd3);

        // Reset while holding a lower half with an output pending
        dma4_rdy = 1'b0;
        send(k_s, 1'b1);
        send(l_s, 1'b0);
        chk("t6_pre_vld", dma4_vld, 1'b1);
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t6_rst_vld", dma4_vld, 1'b0);
        chk("t6_rst_pkt", pkt_cnt, 32'd0);
        chk("t6_rst_half", half_cnt, 32'd0);
        chk("t6_rst_mask", dma4_pd[2*DW+1:2*DW], 2'b00);
        #3;
        nvdla_core_rstn = 1'b1;
        dma4_rdy = 1'b1;
        step();
        send(j_s, 1'b1);
        chk("t6_vld", dma4_vld, 1'b1);
        chk("t6_pd", dma4_pd, {2'b01, zero_s, j_s});
        step();
        chk("t6_pkt", pkt_cnt, 32'd1);
        chk("t6_half", half_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
